exu_lsu_pipe: RTL and testbench



---
 rtl/exu_lsu_pipe.sv | 255 +++++++++++++++++++++++++
 tb/tb_exu_lsu_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_lsu_pipe.sv
// exu_lsu_pipe: execute stage with valid/ready handshaking on both sides.
// Performs RV32I ALU operations, or load/store address generation followed by
// one blocking data-memory transaction (byte-lane formatting, load alignment
// and sign extension, misalignment detection). Each result carries a ROB tag.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   flush_i                  abort the in-flight instruction, discard result
//   in_valid_i / in_ready_o  upstream handshake; tag_i, aluop_i, alu_opa_i,
//                            alu_opb_i, funct3_i, opcode_load_i,
//                            opcode_store_i, store_data_i, rd_addr_i, rd_wr_i
//   out_valid_o / out_ready_i downstream handshake; out_tag_o, rd_addr_o,
//                            rd_wr_o, rd_wdata_o, exc_misalign_o
//   dmem_*                   data-memory request (addr, rmask, wmask, wdata)
//                            and response (rdata, resp)
//   dbg_state_o              current FSM state (IDLE=0, MEM=1, DRAIN=2, RESULT=3)
//
// Optional: define EXU_PERF_CNT_EN to add perf_alu_cnt_o, perf_mem_cnt_o and
// perf_stall_cnt_o (CNT_W bits each, wrap, reset to 0, unaffected by flush).
//
// aluop_i encoding: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra,
// 8 or, 9 and; any other value yields 0.

module exu_lsu_pipe #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [3:0]       aluop_i,
  input  logic [31:0]      alu_opa_i,
  input  logic [31:0]      alu_opb_i,
  input  logic [2:0]       funct3_i,
  input  logic             opcode_load_i,
  input  logic             opcode_store_i,
  input  logic [31:0]      store_data_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rd_wr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [4:0]       rd_addr_o,
  output logic             rd_wr_o,
  output logic [31:0]      rd_wdata_o,
  output logic             exc_misalign_o,
  output logic [31:0]      dmem_addr_o,
  output logic [3:0]       dmem_rmask_o,
  output logic [3:0]       dmem_wmask_o,
  output logic [31:0]      dmem_wdata_o,
  input  logic [31:0]      dmem_rdata_i,
  input  logic             dmem_resp_i,
`ifdef EXU_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_alu_cnt_o,
  output logic [CNT_W-1:0] perf_mem_cnt_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o,
`endif
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MEM = 2'd1, ST_DRAIN = 2'd2, ST_RESULT = 2'd3} state_e;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;

  state_e           state_q;
  logic [TAG_W-1:0] tag_q;
  logic [4:0]       rd_addr_q;
  logic             rd_wr_q, exc_q, is_load_q;
  logic [31:0]      rd_wdata_q, addr_q, wdata_q;
  logic [3:0]       rmask_q, wmask_q;
  logic [2:0]       funct3_q;

  logic [31:0] alu_d, addr_d, wdata_d, load_d;
  logic [15:0] lane_d;
  logic [3:0]  mask_d;
  logic        misalign_d, is_mem, accept;

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high. in_ready_o is combinational (state, flush_i, out_ready_i) so a
  // result can retire and be replaced in the same cycle. out_valid_o and all
  // result fields are registered and hold steady until out_ready_i.
  assign in_ready_o  = !flush_i && ((state_q == ST_IDLE) || (state_q == ST_RESULT && out_ready_i));
  assign accept      = in_valid_i && in_ready_o;
  assign is_mem      = opcode_load_i || opcode_store_i;
  assign addr_d      = alu_opa_i + alu_opb_i;

  always_comb begin
    alu_d = '0;
    case (aluop_i)
      ALU_ADD:  alu_d = alu_opa_i + alu_opb_i;
      ALU_SUB:  alu_d = alu_opa_i - alu_opb_i;
      ALU_SLL:  alu_d = alu_opa_i << alu_opb_i[4:0];
      ALU_SLT:  alu_d = {31'd0, $signed(alu_opa_i) < $signed(alu_opb_i)};
      ALU_SLTU: alu_d = {31'd0, alu_opa_i < alu_opb_i};
      ALU_XOR:  alu_d = alu_opa_i ^ alu_opb_i;
      ALU_SRL:  alu_d = alu_opa_i >> alu_opb_i[4:0];
      ALU_SRA:  alu_d = $signed(alu_opa_i) >>> alu_opb_i[4:0];
      ALU_OR:   alu_d = alu_opa_i | alu_opb_i;
      ALU_AND:  alu_d = alu_opa_i & alu_opb_i;
      default:  alu_d = '0;
    endcase
  end

  // Width from funct3[1:0]: 0 byte, 1 half, 2/3 word (covers funct3 3, 6, 7).
  always_comb begin
    mask_d     = 4'b1111;
    misalign_d = 1'b0;
    wdata_d    = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        mask_d  = 4'b0001 << addr_d[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        mask_d     = addr_d[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{store_data_i[15:0]}};
        misalign_d = addr_d[0];
      end
      default: misalign_d = |addr_d[1:0];
    endcase
    // Keep only the selected lanes; unselected lanes are driven to 0.
    wdata_d = wdata_d & {{8{mask_d[3]}}, {8{mask_d[2]}}, {8{mask_d[1]}}, {8{mask_d[0]}}};
  end

  // Load formatting: move the addressed lane down to bit 0, then extend.
  always_comb begin
    lane_d = 16'(dmem_rdata_i >> {addr_q[1:0], 3'b000});
    load_d = dmem_rdata_i;
    case (funct3_q[1:0])
      2'b00:   load_d = funct3_q[2] ? {24'd0, lane_d[7:0]} : {{24{lane_d[7]}}, lane_d[7:0]};
      2'b01:   load_d = funct3_q[2] ? {16'd0, lane_d} : {{16{lane_d[15]}}, lane_d};
      default: load_d = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tag_q      <= '0;
      rd_addr_q  <= '0;
      rd_wr_q    <= 1'b0;
      exc_q      <= 1'b0;
      is_load_q  <= 1'b0;
      rd_wdata_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      funct3_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESULT: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
          end else if (accept) begin
            tag_q <= tag_i;
            if (is_mem) begin
              addr_q     <= addr_d;
              funct3_q   <= funct3_i;
              is_load_q  <= opcode_load_i;
              rd_addr_q  <= opcode_load_i ? rd_addr_i : 5'd0;
              rd_wdata_q <= '0;
              if (misalign_d) begin
                // Fault reported directly; memory is never touched.
                exc_q   <= 1'b1;
                rd_wr_q <= 1'b0;
                rmask_q <= '0;
                wmask_q <= '0;
                state_q <= ST_RESULT;
              end else begin
                exc_q   <= 1'b0;
                rd_wr_q <= opcode_load_i && rd_wr_i;
                rmask_q <= opcode_load_i ? mask_d : 4'b0000;
                wmask_q <= opcode_load_i ? 4'b0000 : mask_d;
                wdata_q <= opcode_load_i ? 32'd0 : wdata_d;
                state_q <= ST_MEM;
              end
            end else begin
              rd_addr_q  <= rd_addr_i;
              rd_wr_q    <= rd_wr_i;
              rd_wdata_q <= alu_d;
              exc_q      <= 1'b0;
              state_q    <= ST_RESULT;
            end
          end else if (state_q == ST_RESULT && out_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_MEM: begin
          if (dmem_resp_i) begin
            rmask_q <= '0;
            wmask_q <= '0;
            if (is_load_q) rd_wdata_q <= load_d;
            // A flush coinciding with the response discards the result.
            state_q <= flush_i ? ST_IDLE : ST_RESULT;
          end else if (flush_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Request stays up until memory answers; the answer is dropped.
          if (dmem_resp_i) begin
            rmask_q <= '0;
            wmask_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid_o    = (state_q == ST_RESULT);
  assign out_tag_o      = tag_q;
  assign rd_addr_o      = rd_addr_q;
  assign rd_wr_o        = rd_wr_q;
  assign rd_wdata_o     = rd_wdata_q;
  assign exc_misalign_o = exc_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_rmask_o   = rmask_q;
  assign dmem_wmask_o   = wmask_q;
  assign dmem_wdata_o   = wdata_q;
  assign dbg_state_o    = state_q;

`ifdef EXU_PERF_CNT_EN
  logic [CNT_W-1:0] alu_cnt_q, mem_cnt_q, stall_cnt_q;
  logic             res_mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_cnt_q   <= '0;
      mem_cnt_q   <= '0;
      stall_cnt_q <= '0;
      res_mem_q   <= 1'b0;
    end else begin
      if (accept) res_mem_q <= is_mem;
      if (out_valid_o && out_ready_i) begin
        if (res_mem_q) mem_cnt_q <= mem_cnt_q + 1'b1;
        else           alu_cnt_q <= alu_cnt_q + 1'b1;
      end
      if (out_valid_o && !out_ready_i) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign perf_alu_cnt_o   = alu_cnt_q;
  assign perf_mem_cnt_o   = mem_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exu_lsu_pipe.sv
// Bench for exu_lsu_pipe: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.

module tb_exu_lsu_pipe;
  localparam int TAG_W = 4;
  localparam int CNT_W = 32;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SRA = 4'd7;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rst_i, flush_i, in_valid_i, in_ready_o;
  logic [TAG_W-1:0] tag_i, out_tag_o;
  logic [3:0]       aluop_i;
  logic [31:0]      alu_opa_i, alu_opb_i, store_data_i;
  logic [2:0]       funct3_i;
  logic             opcode_load_i, opcode_store_i;
  logic [4:0]       rd_addr_i, rd_addr_o;
  logic             rd_wr_i, out_valid_o, out_ready_i, rd_wr_o, exc_misalign_o;
  logic [31:0]      rd_wdata_o, dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]       dmem_rmask_o, dmem_wmask_o;
  logic             dmem_resp_i;
  logic [1:0]       dbg_state;
`ifdef EXU_PERF_CNT_EN
  logic [CNT_W-1:0] perf_alu_cnt_o, perf_mem_cnt_o, perf_stall_cnt_o;
`endif

  exu_lsu_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .tag_i(tag_i),
    .aluop_i(aluop_i), .alu_opa_i(alu_opa_i), .alu_opb_i(alu_opb_i),
    .funct3_i(funct3_i), .opcode_load_i(opcode_load_i), .opcode_store_i(opcode_store_i),
    .store_data_i(store_data_i), .rd_addr_i(rd_addr_i), .rd_wr_i(rd_wr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tag_o(out_tag_o),
    .rd_addr_o(rd_addr_o), .rd_wr_o(rd_wr_o), .rd_wdata_o(rd_wdata_o),
    .exc_misalign_o(exc_misalign_o), .dmem_addr_o(dmem_addr_o),
    .dmem_rmask_o(dmem_rmask_o), .dmem_wmask_o(dmem_wmask_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_resp_i(dmem_resp_i),
`ifdef EXU_PERF_CNT_EN
    .perf_alu_cnt_o(perf_alu_cnt_o), .perf_mem_cnt_o(perf_mem_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase flags: waiting on memory, draining a flushed access, holding a result.
  bit               m_mem = 0, m_drain = 0, m_res = 0;
  logic [TAG_W-1:0] e_tag = '0;
  logic [4:0]       e_rd = '0;
  bit               e_rw = 0, e_exc = 0, e_is_mem = 0;
  logic [31:0]      e_wd = '0, e_addr = '0, e_dw = '0;
  logic [3:0]       e_rm = '0, e_wm = '0;
  int               p_bytes = 4, p_off = 0;
  bit               p_load = 0, p_signed = 0;
  logic [CNT_W-1:0] e_pa = '0, e_pm = '0, e_ps = '0;
  logic [42:0]      exp_q[$];

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sh;
    logic [31:0] r;
    sh = int'(b[4:0]);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] rdata);
    longint unsigned v, span;
    span = 64'd1 << (8 * p_bytes);
    v = (64'(rdata) >> (8 * p_off)) & (span - 1);
    if (p_signed && p_bytes < 4 && v >= (span >> 1)) v = v - span;
    return v[31:0];
  endfunction

  function automatic bit m_in_ready();
    return !flush_i && ((!m_mem && !m_drain && !m_res) || (m_res && out_ready_i));
  endfunction

  task automatic push_exp();
    exp_q.push_back({e_exc, e_rw, e_rd, e_tag, e_wd});
  endtask

  always @(posedge clk_i) begin
    bit acc;
    logic [31:0] a;
    longint unsigned v;
    if (rst_i) begin
      m_mem = 0; m_drain = 0; m_res = 0; e_rm = '0; e_wm = '0;
      e_pa = '0; e_pm = '0; e_ps = '0;
      e_tag = '0; e_rd = '0; e_rw = 0; e_exc = 0; e_wd = '0;
      exp_q.delete();
    end else begin
      acc = in_valid_i && m_in_ready();
      if (m_res) begin
        if (out_ready_i) begin
          if (e_is_mem) e_pm = e_pm + 1'b1;
          else          e_pa = e_pa + 1'b1;
        end else begin
          e_ps = e_ps + 1'b1;
        end
      end
      if (m_mem || m_drain) begin
        if (dmem_resp_i) begin
          if (m_mem && !flush_i) begin
            if (p_load) e_wd = load_model(dmem_rdata_i);
            m_res = 1;
            push_exp();
          end
          m_mem = 0; m_drain = 0; e_rm = '0; e_wm = '0;
        end else if (m_mem && flush_i) begin
          m_mem = 0; m_drain = 1;
        end
      end else if (flush_i) begin
        if (m_res && !out_ready_i && exp_q.size() > 0) void'(exp_q.pop_back());
        m_res = 0;
      end else if (acc) begin
        m_res = 0;
        e_tag = tag_i;
        e_is_mem = opcode_load_i || opcode_store_i;
        if (!e_is_mem) begin
          e_rd = rd_addr_i; e_rw = rd_wr_i; e_exc = 0;
          e_wd = alu_model(aluop_i, alu_opa_i, alu_opb_i);
          m_res = 1;
          push_exp();
        end else begin
          a = alu_opa_i + alu_opb_i;
          p_bytes  = (funct3_i[1:0] == 2'd0) ? 1 : (funct3_i[1:0] == 2'd1) ? 2 : 4;
          p_off    = int'(a % 4);
          p_load   = opcode_load_i;
          p_signed = !funct3_i[2];
          e_rd = opcode_load_i ? rd_addr_i : 5'd0;
          e_wd = '0;
          if ((a % p_bytes) != 0) begin
            e_exc = 1; e_rw = 0; m_res = 1;
            push_exp();
          end else begin
            e_exc = 0; e_rw = opcode_load_i && rd_wr_i; e_addr = a; m_mem = 1;
            v = ((64'd1 << p_bytes) - 1) << p_off;
            if (opcode_load_i) e_rm = v[3:0];
            else               e_wm = v[3:0];
            v = (64'(store_data_i) & ((64'd1 << (8 * p_bytes)) - 1)) << (8 * p_off);
            e_dw = v[31:0];
          end
        end
      end else if (m_res && out_ready_i) begin
        m_res = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    #1;
    if (chk_en) begin
      chk("in_ready", 64'(in_ready_o), 64'(m_in_ready()));
      chk("out_valid", 64'(out_valid_o), 64'(m_res));
      chk("rmask", 64'(dmem_rmask_o), 64'(e_rm));
      chk("wmask", 64'(dmem_wmask_o), 64'(e_wm));
      if (e_rm != 4'd0 || e_wm != 4'd0) chk("dmem_addr", 64'(dmem_addr_o), 64'(e_addr));
      if (e_wm != 4'd0) chk("dmem_wdata", 64'(dmem_wdata_o), 64'(e_dw));
      if (m_res) begin
        chk("out_tag", 64'(out_tag_o), 64'(e_tag));
        chk("rd_addr", 64'(rd_addr_o), 64'(e_rd));
        chk("rd_wr", 64'(rd_wr_o), 64'(e_rw));
        chk("rd_wdata", 64'(rd_wdata_o), 64'(e_wd));
        chk("exc_misalign", 64'(exc_misalign_o), 64'(e_exc));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) chk("retire_unexpected", 64'(1), 64'(0));
        else chk("retire", 64'({exc_misalign_o, rd_wr_o, rd_addr_o, out_tag_o, rd_wdata_o}),
                 64'(exp_q.pop_front()));
      end
`ifdef EXU_PERF_CNT_EN
      chk("perf_alu", 64'(perf_alu_cnt_o), 64'(e_pa));
      chk("perf_mem", 64'(perf_mem_cnt_o), 64'(e_pm));
      chk("perf_stall", 64'(perf_stall_cnt_o), 64'(e_ps));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    rst_i = 0; flush_i = 0; in_valid_i = 0; opcode_load_i = 0; opcode_store_i = 0;
    dmem_resp_i = 0; dmem_rdata_i = $urandom(); out_ready_i = 1;
  endtask

  task automatic issue_mem(input bit ld, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] off, input logic [31:0] sd);
    in_valid_i = 1; opcode_load_i = ld; opcode_store_i = !ld; funct3_i = f3;
    alu_opa_i = base; alu_opb_i = off; store_data_i = sd;
    rd_addr_i = 5'd7; rd_wr_i = 1; tag_i = 4'd4; aluop_i = OP_ADD;
  endtask

  task automatic load_test(input logic [2:0] f3, input logic [31:0] exp);
    nxt(); idle_inputs(); issue_mem(1, f3, 32'h1000, 32'd3, 32'd0);
    nxt(); idle_inputs();
    #2 chk("lb_rmask_c1", 64'(dmem_rmask_o), 64'h8);
    nxt(); idle_inputs();
    #2 chk("lb_rmask_c2", 64'(dmem_rmask_o), 64'h8);
    nxt(); idle_inputs(); dmem_resp_i = 1; dmem_rdata_i = 32'h80FF_FFFF;
    #2 chk("lb_rmask_c3", 64'(dmem_rmask_o), 64'h8);
    nxt(); idle_inputs();
    #2 chk("lb_valid", 64'(out_valid_o), 64'd1);
    chk("lb_data", 64'(rd_wdata_o), 64'(exp));
    chk("lb_rmask_drop", 64'(dmem_rmask_o), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    logic [CNT_W-1:0] stall0;
    idle_inputs(); rst_i = 1; tag_i = '0; aluop_i = '0; alu_opa_i = '0; alu_opb_i = '0;
    funct3_i = '0; store_data_i = '0; rd_addr_i = '0; rd_wr_i = 0;
    nxt(); nxt();
    idle_inputs(); chk_en = 1;
    #2 chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_masks", 64'({dmem_rmask_o, dmem_wmask_o}), 64'd0);
    chk("rst_rd_wr", 64'(rd_wr_o), 64'd0);
    chk("rst_data", 64'({rd_wdata_o, dmem_addr_o}), 64'd0);
    chk("rst_tag_exc", 64'({out_tag_o, exc_misalign_o}), 64'd0);

    // add then sra back-to-back
    nxt(); idle_inputs(); in_valid_i = 1; aluop_i = OP_ADD; alu_opa_i = 5; alu_opb_i = 7;
    tag_i = 4'd1; rd_addr_i = 5'd3; rd_wr_i = 1;
    #2 chk("add_in_ready", 64'(in_ready_o), 64'd1);
    nxt(); aluop_i = OP_SRA; alu_opa_i = 32'h8000_0000; alu_opb_i = 4; tag_i = 4'd2;
    #2 chk("add_result", 64'(rd_wdata_o), 64'h0000_000C);
    chk("b2b_in_ready", 64'(in_ready_o), 64'd1);
    nxt(); in_valid_i = 0;
    #2 chk("sra_result", 64'(rd_wdata_o), 64'hF800_0000);
    chk("sra_tag", 64'(out_tag_o), 64'd2);

    load_test(3'd0, 32'hFFFF_FF80);
    load_test(3'd4, 32'h0000_0080);

    // sh at 0x2002
    nxt(); idle_inputs(); issue_mem(0, 3'd1, 32'h2000, 32'd2, 32'h1234_ABCD);
    nxt(); idle_inputs(); dmem_resp_i = 1;
    #2 chk("sh_wmask", 64'(dmem_wmask_o), 64'hC);
    chk("sh_wdata", 64'(dmem_wdata_o), 64'hABCD_0000);
    nxt(); idle_inputs();
    #2 chk("sh_valid", 64'(out_valid_o), 64'd1);
    chk("sh_rd_wr", 64'(rd_wr_o), 64'd0);
    chk("sh_rd_addr", 64'(rd_addr_o), 64'd0);

    // misaligned lw at 0x3001
    nxt(); idle_inputs(); issue_mem(1, 3'd2, 32'h3000, 32'd1, 32'd0);
    nxt(); idle_inputs();
    #2 chk("lw_mis_valid", 64'(out_valid_o), 64'd1);
    chk("lw_mis_exc", 64'(exc_misalign_o), 64'd1);
    chk("lw_mis_masks", 64'({dmem_rmask_o, dmem_wmask_o}), 64'd0);

    // result held 4 cycles with out_ready_i=0
    nxt(); idle_inputs(); out_ready_i = 0; in_valid_i = 1; aluop_i = OP_ADD;
    alu_opa_i = 32'h10; alu_opb_i = 32'h20; tag_i = 4'd9;
    nxt(); idle_inputs(); out_ready_i = 0;
`ifdef EXU_PERF_CNT_EN
    stall0 = perf_stall_cnt_o;
`else
    stall0 = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin nxt(); idle_inputs(); out_ready_i = 0; in_valid_i = 1; end
      #2 chk("hold_data", 64'(rd_wdata_o), 64'h30);
      chk("hold_in_ready", 64'(in_ready_o), 64'd0);
    end
    nxt(); idle_inputs();
`ifdef EXU_PERF_CNT_EN
    #2 chk("hold_stall_cnt", 64'(perf_stall_cnt_o - stall0), 64'd4);
`endif

    // flush during MEM of a load
    nxt(); idle_inputs(); issue_mem(1, 3'd0, 32'h1000, 32'd3, 32'd0);
    nxt(); idle_inputs(); flush_i = 1;
    #2 chk("fl_rmask_c1", 64'(dmem_rmask_o), 64'h8);
    nxt(); idle_inputs();
    #2 chk("fl_rmask_c2", 64'(dmem_rmask_o), 64'h8);
    nxt(); idle_inputs(); dmem_resp_i = 1;
    #2 chk("fl_rmask_c3", 64'(dmem_rmask_o), 64'h8);
    nxt(); idle_inputs();
    #2 chk("fl_rmask_drop", 64'(dmem_rmask_o), 64'd0);
    chk("fl_no_valid", 64'(out_valid_o), 64'd0);
    chk("fl_in_ready", 64'(in_ready_o), 64'd1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      nxt();
      rst_i        = ($urandom_range(0, 199) == 0);
      flush_i      = ($urandom_range(0, 9) == 0);
      out_ready_i  = ($urandom_range(0, 9) < 7);
      dmem_resp_i  = ($urandom_range(0, 9) < 4);
      dmem_rdata_i = $urandom();
      in_valid_i   = 1'($urandom_range(0, 1));
      kind         = $urandom_range(0, 3);
      opcode_load_i  = (kind == 2);
      opcode_store_i = (kind == 3);
      aluop_i      = 4'($urandom_range(0, 11));
      alu_opa_i    = $urandom();
      alu_opb_i    = (kind >= 2) ? 32'($urandom_range(0, 15)) : $urandom();
      funct3_i     = 3'($urandom_range(0, 7));
      tag_i        = 4'($urandom_range(0, 15));
      rd_addr_i    = 5'($urandom_range(0, 31));
      rd_wr_i      = 1'($urandom_range(0, 1));
      store_data_i = $urandom();
    end

    nxt(); idle_inputs();
    repeat (4) nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
